// File: rtl/fifo_uart_streamer.sv
// rtl/fifo_uart_streamer.sv - Drains the sample FIFO one word at a time onto a UART 8N1 line, MSB byte first.
// Optional FRAME_HDR_EN macro prefixes every sample with a 0xA5 sync byte.
module fifo_uart_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  uart_tx,
    output logic                  busy,
    output logic [15:0]           sample_count
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef FRAME_HDR_EN
    localparam int BYTE_W       = 2;
    localparam int NUM_BYTES    = 3;
`else
    localparam int BYTE_W       = 1;
    localparam int NUM_BYTES    = 2;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_START, S_DATA, S_STOP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [15:0]         shadow_q, shadow_d;
    logic [15:0]         count_q, count_d;
    logic                tx_c, rd_c, baud_end;
    logic [7:0]          cur_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
`ifdef FRAME_HDR_EN
        case (byte_q)
            2'd0:    cur_byte = 8'hA5;
            2'd1:    cur_byte = shadow_q[15:8];
            default: cur_byte = shadow_q[7:0];
        endcase
`else
        cur_byte = byte_q[0] ? shadow_q[7:0] : shadow_q[15:8];
`endif
    end

    assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shadow_d = shadow_q;
        count_d  = count_q;
        tx_c     = 1'b1;
        rd_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && !fifo_empty) state_d = S_FETCH;
            end
            S_FETCH: begin
                rd_c    = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                shadow_d = 16'(fifo_data);
                byte_d   = '0;
                bit_d    = '0;
                baud_d   = '0;
                state_d  = S_START;
            end
            S_START: begin
                tx_c = 1'b0;
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                tx_c = cur_byte[bit_q];
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else bit_d = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q == BYTE_W'(NUM_BYTES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        byte_d  = byte_q + BYTE_W'(1);
                        state_d = S_START;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DONE: begin
                count_d = count_q + 16'd1;
                // Back-to-back path skips IDLE to keep the gap at three idle cycles
                state_d = (enable && !fifo_empty) ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign uart_tx      = tx_c;
    assign fifo_rd_en   = rd_c;
    assign busy         = (state_q != S_IDLE);
    assign sample_count = count_q;
endmodule

// File: tb/tb_fifo_uart_streamer.sv
// tb/tb_fifo_uart_streamer.sv - Self-checking bench for fifo_uart_streamer against a waveform-level model.
module tb_fifo_uart_streamer;
    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data = '0;
    logic        fifo_rd_en, uart_tx, busy;
    logic [15:0] sample_count;

    logic        en12 = 1'b0;
    logic        empty12 = 1'b1;
    logic [11:0] data12 = '0;
    logic        rd12, tx12, busy12;
    logic [15:0] cnt12;

    fifo_uart_streamer #(.DATA_WIDTH(16), .CLK_FREQ(16), .BAUD_RATE(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .uart_tx(uart_tx),
        .busy(busy), .sample_count(sample_count)
    );

    fifo_uart_streamer #(.DATA_WIDTH(12), .CLK_FREQ(16), .BAUD_RATE(1)) u12 (
        .clk(clk), .rst_n(rst_n), .enable(en12), .fifo_empty(empty12),
        .fifo_data(data12), .fifo_rd_en(rd12), .uart_tx(tx12),
        .busy(busy12), .sample_count(cnt12)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic rd;
        logic bsy;
        logic inc;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fq[$];
    logic [15:0] mq[$];
    exp_t        eq[$];
    exp_t        cur = 4'b1000;
    int          mcnt = 0;
    logic [7:0]  rxq[$];
    int          rdcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic tx, input logic rd, input logic bsy, input logic inc);
        exp_t e;
        e.tx = tx; e.rd = rd; e.bsy = bsy; e.inc = inc;
        return e;
    endfunction

    function automatic void push_bit(input logic b);
        for (int k = 0; k < CPB; k++) eq.push_back(mk(b, 1'b0, 1'b1, 1'b0));
    endfunction

    // Expected line waveform for one sample: fetch, latch, the 8N1 frames, done
    function automatic void build(input logic [15:0] s);
        logic [7:0] bytes[$];
        bytes.delete();
`ifdef FRAME_HDR_EN
        bytes.push_back(8'hA5);
`endif
        bytes.push_back(s[15:8]);
        bytes.push_back(s[7:0]);
        eq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
        eq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0));
        foreach (bytes[j]) begin
            push_bit(1'b0);
            for (int i = 0; i < 8; i++) push_bit(bytes[j][i]);
            push_bit(1'b1);
        end
        eq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq.delete();
            cur  = mk(1'b1, 1'b0, 1'b0, 1'b0);
            mcnt = 0;
        end else begin
            if (cur.inc) mcnt = (mcnt + 1) % 65536;
            if (eq.size() == 0 && enable && mq.size() > 0) build(mq.pop_front());
            if (eq.size() > 0) cur = eq.pop_front();
            else cur = mk(1'b1, 1'b0, 1'b0, 1'b0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("uart_tx", uart_tx, cur.tx);
            chk("fifo_rd_en", fifo_rd_en, cur.rd);
            chk("busy", busy, cur.bsy);
            chk("sample_count", sample_count, mcnt[15:0]);
            if (fifo_rd_en) rdcnt++;
        end
    end

    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_data  = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
    end

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (CPB / 2) @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(posedge clk);
                b[i] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            rxq.push_back(b);
        end
    end

    task automatic push(input logic [15:0] v);
        fq.push_back(v);
        mq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_rd(input string name);
        int n = 0;
        while (!fifo_rd_en && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_rd_timeout"}, fifo_rd_en, 1'b1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_timeout"}, busy, 1'b0);
    endtask

    task automatic chk_rx(input string name, input logic [15:0] samples[$]);
        logic [7:0] exp[$];
        exp.delete();
        foreach (samples[j]) begin
`ifdef FRAME_HDR_EN
            exp.push_back(8'hA5);
`endif
            exp.push_back(samples[j][15:8]);
            exp.push_back(samples[j][7:0]);
        end
        chk({name, "_rx_len"}, rxq.size(), exp.size());
        foreach (exp[j]) if (j < rxq.size()) chk({name, "_rx_byte"}, rxq[j], exp[j]);
    endtask

    initial begin
        int rd0;
        int pushed;
        logic [7:0]  b12[$];
        logic        bits12[$];

        repeat (3) @(negedge clk);
        chk("reset_tx", uart_tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_count", sample_count, 16'h0000);
        chk("reset_rd", fifo_rd_en, 1'b0);
        rst_n = 1'b1;

        enable = 1'b1;
        repeat (200) @(negedge clk);
        chk("t1_no_rd", rdcnt, 0);
        chk("t1_busy", busy, 1'b0);

        rxq.delete();
        rd0 = rdcnt;
        push(16'h1234);
        wait_rd("t2");
        @(negedge clk);
        chk("t2_latch_tx", uart_tx, 1'b1);
        @(negedge clk);
        chk("t2_start_tx", uart_tx, 1'b0);
        wait_idle("t2", 2000);
        chk_rx("t2", '{16'h1234});
        chk("t2_count", sample_count, 16'd1);
        chk("t2_rd_pulses", rdcnt - rd0, 1);

        rxq.delete();
        rd0 = rdcnt;
        push(16'hABCD); push(16'h0001); push(16'hFFFF);
        wait_rd("t3");
        wait_idle("t3", 5000);
        chk_rx("t3", '{16'hABCD, 16'h0001, 16'hFFFF});
        chk("t3_count", sample_count, 16'd4);
        chk("t3_rd_pulses", rdcnt - rd0, 3);

        rxq.delete();
        push(16'h5A5A); push(16'h1111);
        wait_rd("t4");
        repeat (2 + CPB + 40) @(negedge clk);
        enable = 1'b0;
        wait_idle("t4", 2000);
        repeat (20) @(negedge clk);
        chk_rx("t4", '{16'h5A5A});
        chk("t4_count", sample_count, 16'd5);
        chk("t4_left_in_fifo", fq.size(), 1);
        enable = 1'b1;
        wait_rd("t4b");
        wait_idle("t4b", 2000);
        chk("t4b_count", sample_count, 16'd6);

        push(16'hC3C3);
        wait_rd("t5");
        repeat (2 + 10 * CPB + 4 * CPB + 8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_tx_async", uart_tx, 1'b1);
        chk("t5_count_async", sample_count, 16'h0000);
        chk("t5_busy_async", busy, 1'b0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd0 = rdcnt;
        push(16'h0F0F);
        repeat (100) @(negedge clk);
        chk("t5_no_rd_disabled", rdcnt - rd0, 0);
        rxq.delete();
        enable = 1'b1;
        wait_rd("t5b");
        wait_idle("t5b", 2000);
        chk_rx("t5b", '{16'h0F0F});
        chk("t5_count_after", sample_count, 16'd1);

        pushed = 1;
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                push(16'($urandom));
                pushed++;
            end
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            repeat ($urandom_range(1, 400)) @(negedge clk);
        end
        enable = 1'b1;
        for (int n = 0; n < 40000 && (fq.size() > 0 || busy); n++) @(negedge clk);
        chk("rand_drained", fq.size(), 0);
        chk("rand_idle", busy, 1'b0);
        chk("rand_count", sample_count, 16'(pushed));

`ifdef FRAME_HDR_EN
        b12.push_back(8'hA5);
`endif
        b12.push_back(8'h0F);
        b12.push_back(8'hFF);
        foreach (b12[j]) begin
            bits12.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits12.push_back(b12[j][i]);
            bits12.push_back(1'b1);
        end
        en12 = 1'b1;
        empty12 = 1'b0;
        for (int n = 0; n < 100 && !rd12; n++) @(negedge clk);
        chk("t6_rd", rd12, 1'b1);
        data12 = 12'hFFF;
        empty12 = 1'b1;
        en12 = 1'b0;
        repeat (2 + CPB / 2) @(negedge clk);
        foreach (bits12[k]) begin
            chk("t6_bit", tx12, bits12[k]);
            repeat (CPB) @(negedge clk);
        end
        for (int n = 0; n < 100 && busy12; n++) @(negedge clk);
        chk("t6_idle", busy12, 1'b0);
        chk("t6_count", cnt12, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
